// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Optional build macro used by mult_256: MULT_EARLY_EXIT_EN.
package mult_pkg;

  localparam int MULT_N = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_256_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// accumulator, then move the multiplicand left and the multiplier right.
module mult_256_step
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] acc_nxt,
  output logic [2*N-1:0] mcand_nxt,
  output logic [N-1:0]   mplier_nxt
);

  // The 2N-bit sum cannot overflow: the running total never exceeds a*b.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nxt  = {mcand[2*N-2:0], 1'b0};
  assign mplier_nxt = {1'b0, mplier[N-1:1]};

endmodule

// File: rtl/mult_256.sv
// Sequential N x N unsigned multiplier, one multiplier bit per clock.
// Each operation starts on the first edge after reset release and ends
// with data_rdy held high until the next reset.
// Build option MULT_EARLY_EXIT_EN: stop as soon as the remaining
// multiplier bits are all zero (same result, shorter latency).
module mult_256
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] prod,
  output logic [2*N-1:0] acc,
  output logic           data_rdy,
  output logic [1:0]     state
);

  // One extra bit so the counter can represent N without wrapping.
  localparam int CW = $clog2(N) + 1;

  mult_state_t    state_q;
  mult_state_t    state_d;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  logic [2*N-1:0] acc_step;
  logic [2*N-1:0] mcand_step;
  logic [N-1:0]   mplier_step;
  logic           last_iter;

  mult_256_step #(.N(N)) u_step (
    .acc        (acc),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_nxt    (acc_step),
    .mcand_nxt  (mcand_step),
    .mplier_nxt (mplier_step)
  );

`ifdef MULT_EARLY_EXIT_EN
  // No set bits left after this shift means no more additions can happen.
  assign last_iter = (mplier_step == '0) || (cnt_q == CW'(N - 1));
`else
  assign last_iter = (cnt_q == CW'(N - 1));
`endif

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE is terminal until the next reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Operand load, iteration datapath and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc      <= '0;
      prod     <= '0;
      data_rdy <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mcand_q  <= {{N{1'b0}}, a};
          mplier_q <= b;
          cnt_q    <= '0;
          acc      <= '0;
        end
        CALC: begin
          acc      <= acc_step;
          mcand_q  <= mcand_step;
          mplier_q <= mplier_step;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            prod     <= acc_step;
            data_rdy <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_256.sv
// Directed vector bench for mult_256 (N = 256).
module tb_mult_256;

  logic         clk;
  logic         rst;
  logic [255:0] a;
  logic [255:0] b;
  logic [511:0] prod;
  logic [511:0] acc;
  logic         data_rdy;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] p;
    string        name;
  } vec_t;

  vec_t vecs [8];

  mult_256 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .prod     (prod),
    .acc      (acc),
    .data_rdy (data_rdy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edges from reset release to data_rdy, counting the load edge.
  function automatic int exp_edges(input logic [255:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 256; i++) if (bv[i]) hi = i + 1;
    return (hi == 0) ? 2 : hi + 1;
`else
    return 257;
`endif
  endfunction

  task automatic run_op(input logic [255:0] ta, input logic [255:0] tb_v,
                        input logic [511:0] exp, input string name);
    int   edges;
    bit   done;
    bit   st_ok;
    logic [511:0] held;
    rst = 1'b1;
    a = ta;
    b = tb_v;
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    done  = 1'b0;
    st_ok = 1'b1;
    while (!done && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
      // Operands must be ignored after the load edge.
      if (edges == 1) begin
        a = ~ta;
        b = ~tb_v;
      end
      if (data_rdy) begin
        done = 1'b1;
        if (state !== 2'd2) st_ok = 1'b0;
      end else if (state !== 2'd1) begin
        st_ok = 1'b0;
      end
    end
    chk({name, "_done"}, 512'(done), 512'd1);
    chk({name, "_latency"}, 512'(edges), 512'(exp_edges(tb_v)));
    chk({name, "_prod"}, prod, exp);
    chk({name, "_stateseq"}, 512'(st_ok), 512'd1);
    held = prod;
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_hold_prod"}, prod, held);
    chk({name, "_hold_acc"}, acc, exp);
    chk({name, "_hold_rdy"}, 512'(data_rdy), 512'd1);
    chk({name, "_hold_state"}, 512'(state), 512'd2);
  endtask

  initial begin
    vecs[0] = '{256'd5, 256'd12, 512'h3c, "small"};
    vecs[1] = '{{256{1'b1}}, 256'd2, (512'd1 << 257) - 512'd2, "ones_x2"};
    vecs[2] = '{256'd2, 256'hc << 252, 512'h18 << 252, "top_bits_b"};
    vecs[3] = '{256'h8 << 252, 256'd2, 512'd1 << 256, "carry_out"};
    vecs[4] = '{{256{1'b1}}, {256{1'b1}},
                {{63{4'hf}}, 4'he, {63{4'h0}}, 4'h1}, "ones_sq"};
    vecs[5] = '{256'h1234, 256'h5678, 512'h6260060, "mixed"};
    vecs[6] = '{256'h55, 256'd0, 512'd0, "b_zero"};
    vecs[7] = '{256'd0, {256{1'b1}}, 512'd0, "a_zero"};

    rst = 1'b0;
    a = '0;
    b = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_prod", prod, 512'd0);
    chk("rst_acc", acc, 512'd0);
    chk("rst_rdy", 512'(data_rdy), 512'd0);
    chk("rst_state", 512'(state), 512'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);

    // Abort in the middle of an operation, off the clock edge.
    rst = 1'b1;
    a = {256{1'b1}};
    b = {256{1'b1}};
    @(negedge clk);
    rst = 1'b0;
    repeat (101) @(posedge clk);
    #2;
    chk("mid_state_calc", 512'(state), 512'd1);
    chk("mid_acc_nonzero", 512'(acc != '0), 512'd1);
    rst = 1'b1;
    #1;
    chk("abort_prod", prod, 512'd0);
    chk("abort_acc", acc, 512'd0);
    chk("abort_rdy", 512'(data_rdy), 512'd0);
    chk("abort_state", 512'(state), 512'd0);
    run_op(256'd7, 256'd9, 512'd63, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
